sirv_repeater_burst: RTL and testbench

- Parametrised TileLink-A-channel repeater and burst expander, placed between a narrow peripheral master and the fragmenter/width-adapter path.
- An accepted request passes through combinationally on its first beat.
- The request is then re-emitted from a saved copy for a programmed number of extra beats, with optional per-beat address advance.
- Replaces the fixed-width, single-level "repeat" behaviour with a counted repeat plus an abort.

---
 rtl/sirv_repeater_burst.sv | 115 +++++++++++
 tb/tb_sirv_repeater_burst.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sirv_repeater_burst.sv
// TileLink A-channel repeater / burst expander: passes the first beat through, then
// replays a saved copy for io_repeat_cnt extra beats. Define SIRV_REPEATER_ADDR_INC_EN
// to advance the replayed address by BEAT_BYTES per beat (incrementing burst).
module sirv_repeater_burst #(
  parameter int unsigned DW         = 8,
  parameter int unsigned MW         = 1,
  parameter int unsigned AW         = 30,
  parameter int unsigned SW         = 2,
  parameter int unsigned ZW         = 3,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned BEAT_BYTES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] io_repeat_cnt,
  input  logic             io_abort,
  output logic             io_full,
  output logic [CNT_W-1:0] io_cnt,
  output logic             io_enq_ready,
  input  logic             io_enq_valid,
  input  logic [2:0]       io_enq_bits_opcode,
  input  logic [2:0]       io_enq_bits_param,
  input  logic [ZW-1:0]    io_enq_bits_size,
  input  logic [SW-1:0]    io_enq_bits_source,
  input  logic [AW-1:0]    io_enq_bits_address,
  input  logic [MW-1:0]    io_enq_bits_mask,
  input  logic [DW-1:0]    io_enq_bits_data,
  input  logic             io_deq_ready,
  output logic             io_deq_valid,
  output logic [2:0]       io_deq_bits_opcode,
  output logic [2:0]       io_deq_bits_param,
  output logic [ZW-1:0]    io_deq_bits_size,
  output logic [SW-1:0]    io_deq_bits_source,
  output logic [AW-1:0]    io_deq_bits_address,
  output logic [MW-1:0]    io_deq_bits_mask,
  output logic [DW-1:0]    io_deq_bits_data
);

  logic             r_full;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_opcode;
  logic [2:0]       r_param;
  logic [ZW-1:0]    r_size;
  logic [SW-1:0]    r_source;
  logic [AW-1:0]    r_address;
  logic [MW-1:0]    r_mask;
  logic [DW-1:0]    r_data;

  logic             w_enq_fire;
  logic             w_deq_fire;
  logic [AW-1:0]    w_capture_addr;
  logic [AW-1:0]    w_next_addr;

  assign io_full      = r_full;
  assign io_cnt       = r_cnt;
  assign io_enq_ready = io_deq_ready & ~r_full;
  assign io_deq_valid = io_enq_valid | r_full;

  assign io_deq_bits_opcode  = r_full ? r_opcode  : io_enq_bits_opcode;
  assign io_deq_bits_param   = r_full ? r_param   : io_enq_bits_param;
  assign io_deq_bits_size    = r_full ? r_size    : io_enq_bits_size;
  assign io_deq_bits_source  = r_full ? r_source  : io_enq_bits_source;
  assign io_deq_bits_address = r_full ? r_address : io_enq_bits_address;
  assign io_deq_bits_mask    = r_full ? r_mask    : io_enq_bits_mask;
  assign io_deq_bits_data    = r_full ? r_data    : io_enq_bits_data;

  assign w_enq_fire = io_enq_valid & io_enq_ready;
  assign w_deq_fire = io_deq_valid & io_deq_ready;

`ifdef SIRV_REPEATER_ADDR_INC_EN
  // Saved address always holds the address of the next beat to replay (wraps mod 2^AW).
  assign w_capture_addr = io_enq_bits_address + AW'(BEAT_BYTES);
  assign w_next_addr    = r_address + AW'(BEAT_BYTES);
`else
  assign w_capture_addr = io_enq_bits_address;
  assign w_next_addr    = r_address;
`endif

  // Abort wins over replay and capture; enq_ready=0 while full keeps the latter two exclusive.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_full    <= 1'b0;
      r_cnt     <= '0;
      r_opcode  <= '0;
      r_param   <= '0;
      r_size    <= '0;
      r_source  <= '0;
      r_address <= '0;
      r_mask    <= '0;
      r_data    <= '0;
    end else if (io_abort) begin
      r_full <= 1'b0;
      r_cnt  <= '0;
    end else if (r_full && w_deq_fire) begin
      r_address <= w_next_addr;
      if (r_cnt == CNT_W'(1)) begin
        r_full <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end else if (w_enq_fire && (io_repeat_cnt != '0)) begin
      r_full    <= 1'b1;
      r_cnt     <= io_repeat_cnt;
      r_opcode  <= io_enq_bits_opcode;
      r_param   <= io_enq_bits_param;
      r_size    <= io_enq_bits_size;
      r_source  <= io_enq_bits_source;
      r_address <= w_capture_addr;
      r_mask    <= io_enq_bits_mask;
      r_data    <= io_enq_bits_data;
    end
  end

endmodule

// File: tb/tb_sirv_repeater_burst.sv
// Bench for sirv_repeater_burst: a queue of outstanding replay beats is the reference;
// directed scenarios from the test plan plus a randomized soak.
module tb_sirv_repeater_burst;

  localparam int unsigned DW         = 8;
  localparam int unsigned MW         = 1;
  localparam int unsigned AW         = 30;
  localparam int unsigned SW         = 2;
  localparam int unsigned ZW         = 3;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned BEAT_BYTES = 4;
`ifdef SIRV_REPEATER_ADDR_INC_EN
  localparam int unsigned INC = BEAT_BYTES;
`else
  localparam int unsigned INC = 0;
`endif

  typedef struct packed {
    logic [2:0]    opcode;
    logic [2:0]    param;
    logic [ZW-1:0] size;
    logic [SW-1:0] source;
    logic [AW-1:0] address;
    logic [MW-1:0] mask;
    logic [DW-1:0] data;
  } payload_t;

  typedef struct packed {
    logic             deq_valid;
    logic             enq_ready;
    logic             full;
    logic [CNT_W-1:0] cnt;
    payload_t         bits;
  } obs_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] io_repeat_cnt;
  logic             io_abort;
  logic             io_full;
  logic [CNT_W-1:0] io_cnt;
  logic             io_enq_ready;
  logic             io_enq_valid;
  payload_t         enq_p;
  logic             io_deq_ready;
  logic             io_deq_valid;
  payload_t         deq_p;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  payload_t    q[$];   // beats still owed to deq after the pass-through beat

  always #5 clock = ~clock;

  sirv_repeater_burst #(
    .DW(DW), .MW(MW), .AW(AW), .SW(SW), .ZW(ZW), .CNT_W(CNT_W), .BEAT_BYTES(BEAT_BYTES)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .io_repeat_cnt       (io_repeat_cnt),
    .io_abort            (io_abort),
    .io_full             (io_full),
    .io_cnt              (io_cnt),
    .io_enq_ready        (io_enq_ready),
    .io_enq_valid        (io_enq_valid),
    .io_enq_bits_opcode  (enq_p.opcode),
    .io_enq_bits_param   (enq_p.param),
    .io_enq_bits_size    (enq_p.size),
    .io_enq_bits_source  (enq_p.source),
    .io_enq_bits_address (enq_p.address),
    .io_enq_bits_mask    (enq_p.mask),
    .io_enq_bits_data    (enq_p.data),
    .io_deq_ready        (io_deq_ready),
    .io_deq_valid        (io_deq_valid),
    .io_deq_bits_opcode  (deq_p.opcode),
    .io_deq_bits_param   (deq_p.param),
    .io_deq_bits_size    (deq_p.size),
    .io_deq_bits_source  (deq_p.source),
    .io_deq_bits_address (deq_p.address),
    .io_deq_bits_mask    (deq_p.mask),
    .io_deq_bits_data    (deq_p.data)
  );

  function automatic payload_t rand_payload(input logic [AW-1:0] addr);
    payload_t p;
    p.opcode  = 3'($urandom);
    p.param   = 3'($urandom);
    p.size    = ZW'($urandom);
    p.source  = SW'($urandom);
    p.address = addr;
    p.mask    = MW'($urandom);
    p.data    = DW'($urandom);
    return p;
  endfunction

  task automatic drive(input logic v, input logic r, input logic ab,
                       input logic [CNT_W-1:0] rc, input payload_t p);
    io_enq_valid  = v;
    io_deq_ready  = r;
    io_abort      = ab;
    io_repeat_cnt = rc;
    enq_p         = p;
  endtask

  function automatic obs_t dut_obs();
    return {io_deq_valid, io_enq_ready, io_full, io_cnt, deq_p};
  endfunction

  // Owed beats take the channel; otherwise the block is transparent.
  function automatic obs_t model_obs();
    if (q.size() != 0) return {1'b1, 1'b0, 1'b1, CNT_W'(q.size()), q[0]};
    return {io_enq_valid, io_deq_ready, 1'b0, CNT_W'(0), enq_p};
  endfunction

  task automatic model_step();
    obs_t e;
    payload_t b;
    e = model_obs();
    if (io_abort) begin
      q.delete();
    end else if (q.size() != 0) begin
      if (io_deq_ready) void'(q.pop_front());
    end else if (io_enq_valid && e.enq_ready && io_repeat_cnt != '0) begin
      for (int k = 1; k <= int'(io_repeat_cnt); k++) begin
        b = enq_p;
        b.address = enq_p.address + AW'(k * INC);
        q.push_back(b);
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 4'd7, rand_payload(AW'($urandom)));
    reset = 1'b1;
    @(negedge clock);
    n_vec++;
    if (dut_obs() !== model_obs()) begin
      n_err++;
      $display("FAIL reset: got %h want %h", dut_obs(), model_obs());
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_passthrough();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd0, rand_payload(AW'(32'h100)));
      @(negedge clock);
      n_vec++;
      if (dut_obs() !== model_obs() || io_deq_bits_address_chk(AW'(32'h100))) begin
        n_err++;
        $display("FAIL passthrough c%0d: got %h want %h", c, dut_obs(), model_obs());
      end
      model_step();
      @(posedge clock); #1;
    end
  endtask

  function automatic logic io_deq_bits_address_chk(input logic [AW-1:0] a);
    return deq_p.address !== a;
  endfunction

  task automatic test_burst();
    payload_t p;
    p = rand_payload(AW'(32'h100));
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b0, (k == 0) ? 4'd3 : 4'd0, (k == 0) ? p : rand_payload(AW'(32'h200)));
      @(negedge clock);
      n_vec++;
      if (dut_obs() !== model_obs() ||
          (k < 4 && io_deq_bits_address_chk(AW'(32'h100 + k * INC)))) begin
        n_err++;
        $display("FAIL burst k%0d: got %h want %h", k, dut_obs(), model_obs());
      end
      model_step();
      @(posedge clock); #1;
    end
  endtask

  task automatic test_stall();
    logic rdy[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    payload_t p;
    p = rand_payload(AW'($urandom));
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, (k < 5) ? rdy[k] : 1'b1, 1'b0, (k == 0) ? 4'd2 : 4'd9,
            (k == 0) ? p : rand_payload(AW'($urandom)));
      @(negedge clock);
      n_vec++;
      if (dut_obs() !== model_obs()) begin
        n_err++;
        $display("FAIL stall k%0d: got %h want %h", k, dut_obs(), model_obs());
      end
      model_step();
      @(posedge clock); #1;
    end
  endtask

  task automatic test_abort();
    // fire(5), beat2, abort with beat3, new request(1), its repeat, idle abort+fire(3), check
    logic             v[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic             ab[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [CNT_W-1:0] rc[7] = '{4'd5, 4'd0, 4'd0, 4'd1, 4'd0, 4'd3, 4'd0};
    for (int k = 0; k < 7; k++) begin
      drive(v[k], 1'b1, ab[k], rc[k], rand_payload(AW'($urandom)));
      @(negedge clock);
      n_vec++;
      if (dut_obs() !== model_obs()) begin
        n_err++;
        $display("FAIL abort k%0d: got %h want %h", k, dut_obs(), model_obs());
      end
      model_step();
      @(posedge clock); #1;
    end
  endtask

  task automatic test_wrap_reset();
    payload_t p;
    p = rand_payload(AW'(32'h3FFF_FFFC));
    for (int k = 0; k < 3; k++) begin
      drive(k == 0, k != 2, 1'b0, 4'd2, (k == 0) ? p : rand_payload(AW'($urandom)));
      @(negedge clock);
      n_vec++;
      if (dut_obs() !== model_obs() ||
          io_deq_bits_address_chk(AW'(32'h3FFF_FFFC) + AW'(k * INC))) begin
        n_err++;
        $display("FAIL wrap k%0d: got %h want %h", k, dut_obs(), model_obs());
      end
      model_step();
      if (k < 2) begin
        @(posedge clock); #1;
      end
    end
    // Still full (stalled) here; reset between edges must clear it at once.
    io_enq_valid = 1'b0;
    reset = 1'b1;
    #1;
    q.delete();
    n_vec++;
    if (io_full !== 1'b0 || io_cnt !== '0 || io_deq_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got full=%b cnt=%0d valid=%b want 0 0 0", io_full, io_cnt, io_deq_valid);
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [CNT_W-1:0] rc;
    for (int c = 0; c < 400; c++) begin
      rc = ($urandom_range(0, 2) == 0) ? 4'd0 : CNT_W'($urandom);
      drive(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rc,
            rand_payload(($urandom_range(0, 3) == 0) ? AW'(32'h3FFF_FFF0 + $urandom_range(0, 15))
                                                     : AW'($urandom)));
      @(negedge clock);
      n_vec++;
      if (dut_obs() !== model_obs()) begin
        n_err++;
        $display("FAIL random c%0d: got %h want %h", c, dut_obs(), model_obs());
      end
      model_step();
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_passthrough();
    test_burst();
    test_stall();
    test_abort();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
